// File: rtl/inst_fetch_queue.sv
// Fetch stage: drives the instruction-memory word address, captures {pc, word} into a small FIFO
// drained by decode. Optional halt-on-ecall is enabled with `define FETCH_HALT_EN.
module inst_fetch_queue #(
    parameter int          ADDR_W   = 6,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [31:0]       inst_pc,
    output logic              halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [31:0] entry_pc   [DEPTH];
    logic [31:0] entry_inst [DEPTH];

    logic pop;
    logic push;
    logic halt_req;

    assign imem_addr  = fetch_pc_reg[ADDR_W+1:2];
    assign inst_valid = (count_reg != '0);
    assign pop        = inst_valid & inst_ready;
    assign push       = ~redirect_valid & ~halted
                        & ((count_reg < CNT_W'(DEPTH)) | pop);

`ifdef FETCH_HALT_EN
    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    logic halted_reg;

    // An ecall is still enqueued, but fetch freezes on it until a redirect.
    assign halt_req = push & (imem_data == ECALL_WORD);
    assign halted   = halted_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_reg <= 1'b0;
        end else if (redirect_valid) begin
            halted_reg <= 1'b0;
        end else if (halt_req) begin
            halted_reg <= 1'b1;
        end
    end
`else
    assign halt_req = 1'b0;
    assign halted   = 1'b0;
`endif

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        if (redirect_valid) begin
            // Flush wins over everything; a same-cycle pop is simply lost with the rest.
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                if (!halt_req) begin
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
        end
    end

    // Storage needs no reset: entries are only visible while count_reg says they are live.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_pc[gi]   <= fetch_pc_reg;
                    entry_inst[gi] <= imem_data;
                end
            end
        end
    endgenerate

    assign inst_out = inst_valid ? entry_inst[rd_ptr_reg] : 32'h0;
    assign inst_pc  = inst_valid ? entry_pc[rd_ptr_reg]   : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a 64-word combinational instruction memory model.
// Expected values are hand-derived from the memory contents loaded below.
`timescale 1ns/1ps
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        halted;

    logic [31:0] mem [64];

    int tests_run;
    int tests_failed;

    inst_fetch_queue #(
        .ADDR_W   (6),
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short asynchronous reset pulse between clock edges.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] word);
        check_eq({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        check_eq({tag, "_pc"}, inst_pc, pc);
        check_eq({tag, "_out"}, inst_out, word);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]  = 32'h0000_2083;
        mem[1]  = 32'h0040_2103;
        mem[2]  = 32'h0080_2183;
        mem[3]  = 32'h0000_0073;
        mem[63] = 32'hABCD_0063;

        // Reset state
        #2;
        check_eq("rst_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("rst_out", inst_out, 32'h0);
        check_eq("rst_pc", inst_pc, 32'h0);
        check_eq("rst_addr", {26'b0, imem_addr}, 32'd0);
        check_eq("rst_halted", {31'b0, halted}, 32'd0);
        #1;
        rst = 1'b0;

        // 1: streaming at one instruction per cycle
        step();
        check_head("t1_c1", 32'h0, 32'h0000_2083);
        step();
        check_head("t1_c2", 32'h4, 32'h0040_2103);
        step();
        check_head("t1_c3", 32'h8, 32'h0080_2183);

        // 2: back-pressure fills FIFO, then drains without gap or duplicate
        inst_ready = 1'b0;
        pulse_reset();
        for (int i = 0; i < 5; i++) step();
        check_head("t2_hold", 32'h0, 32'h0000_2083);
        check_eq("t2_addr", {26'b0, imem_addr}, 32'd2);
        inst_ready = 1'b1;
        step();
        check_head("t2_d1", 32'h4, 32'h0040_2103);
        step();
        check_head("t2_d2", 32'h8, 32'h0080_2183);

        // 3: redirect flushes FIFO holding pc 4,8; low address bits ignored
        inst_ready = 1'b0;
        pulse_reset();
        step();
        step();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check_head("t3_pre", 32'h4, 32'h0040_2103);
        check_eq("t3_pre_addr", {26'b0, imem_addr}, 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        step();
        redirect_valid = 1'b0;
        check_eq("t3_flush_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("t3_flush_pc", inst_pc, 32'h0);
        check_eq("t3_addr", {26'b0, imem_addr}, 32'd4);
        step();
        check_head("t3_post", 32'h10, 32'h1000_0004);

        // 4: imem_addr wraps while inst_pc keeps counting
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFC;
        step();
        redirect_valid = 1'b0;
        check_eq("t4_addr0", {26'b0, imem_addr}, 32'd63);
        step();
        check_head("t4_fc", 32'hFC, 32'hABCD_0063);
        check_eq("t4_addr1", {26'b0, imem_addr}, 32'd0);
        step();
        check_head("t4_100", 32'h100, 32'h0000_2083);
        check_eq("t4_addr2", {26'b0, imem_addr}, 32'd1);

        // 5: asynchronous reset while FIFO is full
        inst_ready = 1'b0;
        step();
        step();
        check_eq("t5_full_valid", {31'b0, inst_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("t5_rst_out", inst_out, 32'h0);
        check_eq("t5_rst_addr", {26'b0, imem_addr}, 32'd0);
        rst = 1'b0;
        step();
        check_head("t5_restart", 32'h0, 32'h0000_2083);

        // 6: ecall word behaviour
        inst_ready = 1'b1;
        pulse_reset();
        step();
        check_head("t6_0", 32'h0, 32'h0000_2083);
        step();
        check_head("t6_4", 32'h4, 32'h0040_2103);
        step();
        check_head("t6_8", 32'h8, 32'h0080_2183);
        step();
        check_head("t6_c", 32'hC, 32'h0000_0073);
`ifdef FETCH_HALT_EN
        check_eq("t6_halted", {31'b0, halted}, 32'd1);
        check_eq("t6_addr_hold", {26'b0, imem_addr}, 32'd3);
        step();
        check_eq("t6_drained", {31'b0, inst_valid}, 32'd0);
        check_eq("t6_addr_hold2", {26'b0, imem_addr}, 32'd3);
        step();
        check_eq("t6_still_halted", {31'b0, halted}, 32'd1);
        check_eq("t6_still_empty", {31'b0, inst_valid}, 32'd0);
`else
        check_eq("t6_not_halted", {31'b0, halted}, 32'd0);
        check_eq("t6_addr_run", {26'b0, imem_addr}, 32'd4);
        step();
        check_head("t6_10", 32'h10, 32'h1000_0004);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check_eq("t6_redir_halted", {31'b0, halted}, 32'd0);
        check_eq("t6_redir_valid", {31'b0, inst_valid}, 32'd0);
        step();
        check_head("t6_resume", 32'h0, 32'h0000_2083);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
